// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane steering, load extension and
// misalignment rejection over a req/gnt/rvalid data-memory port.
module load_store_unit #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_valid,
  input  logic                 lsu_we,
  input  logic [2:0]           lsu_funct3,
  input  logic [DataWidth-1:0] lsu_addr,
  input  logic [DataWidth-1:0] lsu_wdata,
  output logic                 lsu_ready,
  output logic                 lsu_stall,
  output logic [DataWidth-1:0] rdata_out,
  output logic                 rdata_valid,
  output logic                 store_done,
  output logic                 misaligned,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DataWidth-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state, state_nx;

  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic       we_q;

  logic                 legal;
  logic                 accept;
  logic                 reject;
  logic [DataWidth-1:0] wdata_lane;
  logic [3:0]           wmask_lane;
  logic [DataWidth-1:0] shifted;
  logic [DataWidth-1:0] ext;

  assign lsu_ready = (state == IDLE);
  assign lsu_stall = (state != IDLE);

  // Stores only exist for B/H/W; unsigned variants are load-only.
  always_comb begin
    legal = 1'b0;
    unique case (lsu_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = !lsu_addr[0];
      3'b010:  legal = (lsu_addr[1:0] == 2'b00);
      3'b100:  legal = !lsu_we;
      3'b101:  legal = !lsu_we && !lsu_addr[0];
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && lsu_valid && legal;
  assign reject = (state == IDLE) && lsu_valid && !legal;

  always_comb begin
    wdata_lane = lsu_wdata;
    wmask_lane = 4'b1111;
    unique case (1'b1)
      (lsu_funct3[1:0] == 2'b00): begin
        wdata_lane = {4{lsu_wdata[7:0]}};
        wmask_lane = 4'b0001 << lsu_addr[1:0];
      end
      (lsu_funct3[1:0] == 2'b01): begin
        wdata_lane = {2{lsu_wdata[15:0]}};
        wmask_lane = 4'b0011 << lsu_addr[1:0];
      end
      default: ;
    endcase
    if (!lsu_we)
      wmask_lane = 4'b0000;
  end

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = mem_rdata;
    unique case (f3_q)
      3'b000:  ext = {{(DataWidth-8){shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {{(DataWidth-8){1'b0}}, shifted[7:0]};
      3'b001:  ext = {{(DataWidth-16){shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {{(DataWidth-16){1'b0}}, shifted[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = REQ;
      REQ:     if (mem_gnt) state_nx = we_q ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= 4'b0000;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      store_done  <= 1'b0;
      misaligned  <= 1'b0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      store_done  <= 1'b0;
      misaligned  <= reject;
      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= lsu_we;
        mem_addr  <= {lsu_addr[DataWidth-1:2], 2'b00};
        mem_wdata <= wdata_lane;
        mem_wmask <= wmask_lane;
        off_q     <= lsu_addr[1:0];
        f3_q      <= lsu_funct3;
        we_q      <= lsu_we;
      end
      if (state == REQ && mem_gnt) begin
        mem_req    <= 1'b0;
        store_done <= we_q;
      end
      if (state == WAIT && mem_rvalid) begin
        rdata_out   <= ext;
        rdata_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, rejection,
// grant back-pressure and reset mid-transaction.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        lsu_stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        store_done;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DataWidth(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid   (lsu_valid),
    .lsu_we      (lsu_we),
    .lsu_funct3  (lsu_funct3),
    .lsu_addr    (lsu_addr),
    .lsu_wdata   (lsu_wdata),
    .lsu_ready   (lsu_ready),
    .lsu_stall   (lsu_stall),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .store_done  (store_done),
    .misaligned  (misaligned),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    lsu_valid  = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wd;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] e_addr,
                          input logic [31:0] e_wdata,
                          input logic [3:0] e_mask);
    drive(1'b1, f3, addr, wd);
    mem_gnt = 1'b1;
    tick;
    lsu_valid = 1'b0;
    check({tag, ".req"}, mem_req, 1);
    check({tag, ".we"}, mem_we, 1);
    check({tag, ".addr"}, mem_addr, e_addr);
    check({tag, ".wdata"}, mem_wdata, e_wdata);
    check({tag, ".wmask"}, mem_wmask, e_mask);
    check({tag, ".stall"}, lsu_stall, 1);
    tick;
    mem_gnt = 1'b0;
    check({tag, ".done"}, store_done, 1);
    check({tag, ".req_drop"}, mem_req, 0);
    check({tag, ".ready"}, lsu_ready, 1);
    tick;
    check({tag, ".done_pulse"}, store_done, 0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rd,
                         input logic [31:0] exp);
    drive(1'b0, f3, addr, 32'h0);
    mem_gnt = 1'b1;
    tick;
    lsu_valid = 1'b0;
    check({tag, ".req"}, mem_req, 1);
    check({tag, ".wmask"}, mem_wmask, 0);
    tick;
    mem_gnt = 1'b0;
    check({tag, ".req_drop"}, mem_req, 0);
    check({tag, ".stall"}, lsu_stall, 1);
    tick;
    check({tag, ".early"}, rdata_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick;
    mem_rvalid = 1'b0;
    check({tag, ".valid"}, rdata_valid, 1);
    check({tag, ".data"}, rdata_out, exp);
    check({tag, ".ready"}, lsu_ready, 1);
    tick;
    check({tag, ".pulse"}, rdata_valid, 0);
  endtask

  task automatic do_reject(input string tag, input logic we,
                           input logic [2:0] f3, input logic [31:0] addr);
    drive(we, f3, addr, 32'h0);
    tick;
    lsu_valid = 1'b0;
    check({tag, ".mis"}, misaligned, 1);
    check({tag, ".req"}, mem_req, 0);
    check({tag, ".ready"}, lsu_ready, 1);
    tick;
    check({tag, ".mis_pulse"}, misaligned, 0);
    check({tag, ".req2"}, mem_req, 0);
  endtask

  initial begin
    rst        = 1'b1;
    lsu_valid  = 1'b0;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'b000;
    lsu_addr   = 32'h0;
    lsu_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick;
    tick;
    rst = 1'b0;
    check("rst.req", mem_req, 0);
    check("rst.ready", lsu_ready, 1);
    check("rst.stall", lsu_stall, 0);
    check("rst.wmask", mem_wmask, 0);
    check("rst.rdata", rdata_out, 0);
    check("rst.mis", misaligned, 0);

    do_store("sw", 3'b010, 32'h100, 32'hDEADBEEF,
             32'h100, 32'hDEADBEEF, 4'b1111);
    do_store("sb", 3'b000, 32'h103, 32'h000000AB,
             32'h100, 32'hABABABAB, 4'b1000);
    do_store("sh", 3'b001, 32'h102, 32'h00001234,
             32'h100, 32'h12341234, 4'b1100);

    do_load("lb", 3'b000, 32'h202, 32'h80FF1234, 32'hFFFFFFFF);
    do_load("lbu", 3'b100, 32'h202, 32'h80FF1234, 32'h000000FF);
    do_load("lh", 3'b001, 32'h202, 32'h80FF1234, 32'hFFFF80FF);
    do_load("lhu", 3'b101, 32'h202, 32'h80FF1234, 32'h000080FF);
    do_load("lw", 3'b010, 32'h200, 32'h80FF1234, 32'h80FF1234);
    do_load("lb1", 3'b000, 32'h201, 32'h00007F00, 32'h0000007F);

    do_reject("lw_mis", 1'b0, 3'b010, 32'h101);
    do_reject("lh_mis", 1'b0, 3'b001, 32'h203);
    do_reject("sbu_bad", 1'b1, 3'b100, 32'h200);
    do_reject("f3_011", 1'b0, 3'b011, 32'h200);

    // Grant withheld for 5 cycles while upstream inputs change.
    drive(1'b1, 3'b010, 32'h300, 32'h11223344);
    tick;
    drive(1'b1, 3'b000, 32'h405, 32'h00000055);
    for (int i = 0; i < 5; i++) begin
      check("hold.req", mem_req, 1);
      check("hold.addr", mem_addr, 32'h300);
      check("hold.wdata", mem_wdata, 32'h11223344);
      check("hold.wmask", mem_wmask, 4'b1111);
      check("hold.stall", lsu_stall, 1);
      tick;
    end
    lsu_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick;
    mem_gnt = 1'b0;
    check("hold.done", store_done, 1);
    check("hold.req_drop", mem_req, 0);
    tick;
    check("hold.no_accept", mem_req, 0);

    // Reset while waiting for load data; late rvalid must be ignored.
    drive(1'b0, 3'b010, 32'h200, 32'h0);
    mem_gnt = 1'b1;
    tick;
    lsu_valid = 1'b0;
    tick;
    mem_gnt = 1'b0;
    check("rwait.stall", lsu_stall, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rwait.req", mem_req, 0);
    check("rwait.ready", lsu_ready, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick;
    mem_rvalid = 1'b0;
    check("rwait.no_valid", rdata_valid, 0);
    check("rwait.idle", lsu_ready, 1);
    do_load("lw_after", 3'b010, 32'h200, 32'hCAFEF00D, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side consumer of the RV32I execute stage's ALU result: it treats the effective address as a data-memory access.
- Performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) over a req/gnt/rvalid data-memory handshake.
- Handles byte-lane steering, write masks, load sign/zero extension and misalignment detection.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- DataWidth, 32, data/address width; only 32 is supported (4 byte lanes).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- lsu_valid  input  1  execute stage presents a load/store this cycle.
- lsu_we  input  1  1 = store, 0 = load.
- lsu_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr  input  DataWidth  effective address (ALU result).
- lsu_wdata  input  DataWidth  store data (rs2).
- lsu_ready  output  1  request accepted when lsu_valid && lsu_ready.
- lsu_stall  output  1  transaction in flight; the pipeline must hold.
- rdata_out  output  DataWidth  extended load result.
- rdata_valid  output  1  one-cycle pulse; rdata_out is valid.
- store_done  output  1  one-cycle pulse; store granted.
- misaligned  output  1  one-cycle pulse; request rejected.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  DataWidth  word-aligned address (addr[1:0] = 00).
- mem_wdata  output  DataWidth  lane-replicated store data.
- mem_wmask  output  4  byte write enables, bit i = byte lane i.
- mem_gnt  input  1  memory accepted the request this cycle.
- mem_rvalid  input  1  load data valid on mem_rdata.
- mem_rdata  input  DataWidth  raw memory word.

Behaviour:
- Reset:
  - State = IDLE.
  - mem_req, mem_we, mem_wmask, mem_addr, mem_wdata, rdata_out, rdata_valid, store_done and misaligned all = 0.
  - lsu_ready = 1 (combinational: state == IDLE).
  - lsu_stall = state != IDLE.
- States: IDLE, REQ, WAIT.
- IDLE, on lsu_valid, check alignment:
  - H/HU with addr[0] = 1 is misaligned.
  - W with addr[1:0] != 00 is misaligned.
  - funct3 011/110/111 is rejected the same way, as is any store funct3 other than 000/001/010.
- IDLE, rejected request: misaligned pulses the next cycle, there is no memory access, and the state stays IDLE.
- IDLE, legal request: register offset = addr[1:0], funct3 and we, and drive the mem_* outputs; the next state is REQ (mem_req high the cycle after acceptance).
- REQ:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wmask are held stable until mem_gnt.
  - On mem_gnt with a store: store_done pulses the next cycle, mem_req drops, and the state goes to IDLE.
  - On mem_gnt with a load: mem_req drops and the state goes to WAIT.
- WAIT:
  - mem_rvalid is sampled only in WAIT, so the earliest is the cycle after gnt.
  - On mem_rvalid, rdata_out is registered and rdata_valid pulses the next cycle, coincident with the return to IDLE.
- Store lanes:
  - SB: wdata = {4{wdata[7:0]}}, wmask = 0001 << offset.
  - SH: wdata = {2{wdata[15:0]}}, wmask = 0011 << offset.
  - SW: wdata = wdata, wmask = 1111.
  - Loads: wmask = 0000, we = 0.
- Load extract: shifted = mem_rdata >> (8 * offset).
  - B: sign-extend shifted[7:0].
  - BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0].
  - HU: zero-extend shifted[15:0].
  - W: mem_rdata unchanged.
- Throughput: the minimum load is accept → req (gnt same cycle) → rvalid → result, 3 cycles. A new request can be accepted in the same cycle rdata_valid/store_done pulses.
- lsu_valid is ignored outside IDLE; the upstream stage holds its inputs while lsu_stall = 1.
- Reset mid-transaction: the state is IDLE the next cycle and mem_req = 0. A late mem_gnt/mem_rvalid afterwards is ignored, and no rdata_valid or store_done is produced.
- mem_rvalid while in IDLE or REQ is ignored.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt on the first req cycle → mem_addr 0x100, wmask 1111, wdata 0xDEADBEEF; store_done pulses 1 cycle after gnt; lsu_ready returns to 1.
- SB addr 0x103, data 0x000000AB → mem_addr 0x100, wdata 0xABABABAB, wmask 1000. SH addr 0x102, data 0x1234 → wdata 0x12341234, wmask 1100.
- Loads at addr 0x202 with mem_rdata 0x80FF1234 and rvalid 2 cycles after gnt:
  - LB → 0xFFFFFFFF.
  - LBU → 0x000000FF.
  - LH → 0xFFFF80FF.
  - LHU → 0x000080FF.
  - LW at 0x200 → 0x80FF1234.
  - rdata_valid is exactly 1 cycle wide in every case.
- LW addr 0x101 → misaligned pulses 1 cycle, mem_req never asserts, lsu_ready stays 1. LH addr 0x203 → same result.
- SW with mem_gnt held low 5 cycles → mem_req/addr/wdata/wmask stable all 5 cycles, lsu_stall = 1 throughout; a changed lsu_* input during the stall has no effect.
- rst asserted in WAIT, then mem_rvalid the following cycle → IDLE, mem_req = 0, no rdata_valid; the next LW at 0x200 completes normally.
